// File: rtl/modn_dnctr_if.sv
// Control and status bundle for the modulo-N down counter.
// The master drives the controls and the slave (the counter) returns the count and status.
interface modn_dnctr_if #(
  parameter int WIDTH = 4
);
  // There is no valid/ready handshake. Each control is a level that is sampled on the rising clock edge.
  // start is sampled in IDLE and DONE, en in RUN, and auto on the terminal edge. load is sampled in every state and has priority.
  logic             start;
  logic             en;
  logic             auto;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, en, auto, load, load_val,
    input  out, tc, busy, done, err
  );

  modport slave (
    input  start, en, auto, load, load_val,
    output out, tc, busy, done, err
  );
endinterface

// File: rtl/modn_dnctr.sv
// Modulo-N down counter with an IDLE/RUN/DONE control FSM and one-shot or auto-reload modes.
// It also supports a synchronous load with range checking and a sticky error flag.
module modn_dnctr #(
  parameter int N     = 10,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  modn_dnctr_if.slave      bus,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAX = WIDTH'(N - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             tc_q, tc_d;
  logic             err_q, err_d;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    tc_d    = 1'b0;
    err_d   = err_q;
    // A load overrides counting and any state change, including one on the terminal edge.
    if (bus.load) begin
      if (bus.load_val > MAX) begin
        out_d = MAX;
        err_d = 1'b1;
      end else begin
        out_d = bus.load_val;
        err_d = 1'b0;
      end
    end else begin
      case (state_q)
        S_IDLE: if (bus.start) state_d = S_RUN;
        S_RUN: begin
          if (bus.en) begin
            if (out_q == '0) begin
              out_d = MAX;
              tc_d  = 1'b1;
              if (!bus.auto) state_d = S_DONE;
            end else begin
              out_d = out_q - WIDTH'(1);
            end
          end
        end
        S_DONE: if (bus.start) state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      out_q   <= MAX;
      tc_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      tc_q    <= tc_d;
      err_q   <= err_d;
    end
  end

  assign bus.out   = out_q;
  assign bus.tc    = tc_q;
  assign bus.err   = err_q;
  assign bus.busy  = (state_q == S_RUN);
  assign bus.done  = (state_q == S_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_modn_dnctr.sv
// Testbench for modn_dnctr. Directed scenarios and a random run are checked against a modular-arithmetic reference model.
module tb_modn_dnctr;
  localparam int N     = 10;
  localparam int WIDTH = 4;
  localparam int W     = WIDTH + 4;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  modn_dnctr_if #(.WIDTH(WIDTH)) bus ();

  modn_dnctr #(.N(N), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: mode 0 = idle, 1 = counting, 2 = finished
  int         m_mode;
  int         m_cnt;
  bit         m_tc;
  bit         m_err;
  logic [W-1:0] exp_q[$];
  int         checks;
  int         errors;

  function automatic logic [W-1:0] pack_exp();
    logic [WIDTH-1:0] c;
    c = WIDTH'(m_cnt);
    return {c, m_tc, (m_mode == 1), (m_mode == 2), m_err};
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_cnt  = N - 1;
    m_tc   = 0;
    m_err  = 0;
  endtask

  task automatic model_step();
    m_tc = 0;
    if (bus.load) begin
      if (int'(bus.load_val) < N) begin
        m_cnt = int'(bus.load_val);
        m_err = 0;
      end else begin
        m_cnt = N - 1;
        m_err = 1;
      end
    end else if (m_mode != 1 && bus.start) begin
      m_mode = 1;
    end else if (m_mode == 1 && bus.en) begin
      if (m_cnt == 0) begin
        m_tc = 1;
        if (!bus.auto) m_mode = 2;
      end
      m_cnt = (m_cnt + N - 1) % N;
    end
    exp_q.push_back(pack_exp());
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input bit s, input bit e, input bit a, input bit l, input int lv);
    bus.start    = s;
    bus.en       = e;
    bus.auto     = a;
    bus.load     = l;
    bus.load_val = WIDTH'(lv);
  endtask

  function automatic logic [W-1:0] got_vec();
    return {bus.out, bus.tc, bus.busy, bus.done, bus.err};
  endfunction

  task automatic test_reset();
    logic [W-1:0] rst_exp;
    rst_exp = {4'd9, 1'b0, 1'b0, 1'b0, 1'b0};
    drive(1, 1, 1, 1, 3);
    rst = 1'b1;
    #1;
    checks++;
    if (got_vec() !== rst_exp) begin
      errors++;
      $display("FAIL reset_async got %h exp %h", got_vec(), rst_exp);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (got_vec() !== rst_exp) begin
      errors++;
      $display("FAIL reset_held got %h exp %h", got_vec(), rst_exp);
    end
    drive(0, 0, 0, 0, 0);
    rst = 1'b0;
    model_reset();
    exp_q.delete();
    cyc();
    checks++;
    if (got_vec() !== exp_q.pop_front()) begin
      errors++;
      $display("FAIL reset_release got %h exp %h", got_vec(), pack_exp());
    end
  endtask

  task automatic test_oneshot();
    drive(1, 1, 0, 0, 0);
    cyc();
    drive(0, 1, 0, 0, 0);
    void'(exp_q.pop_front());
    checks++;
    if (bus.out !== 4'd9 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_start got out=%0d busy=%b exp out=9 busy=1", bus.out, bus.busy);
    end
    for (int i = 1; i <= 11; i++) begin
      logic [W-1:0] e;
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (got_vec() !== e) begin
        errors++;
        $display("FAIL oneshot_cyc%0d got %h exp %h", i, got_vec(), e);
      end
      if (i <= 9) begin
        checks++;
        if (bus.out !== WIDTH'(9 - i)) begin
          errors++;
          $display("FAIL oneshot_seq%0d got %0d exp %0d", i, bus.out, 9 - i);
        end
      end
      if (i == 10) begin
        checks++;
        if ({bus.out, bus.tc, bus.done, bus.busy} !== {4'd9, 1'b1, 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL oneshot_terminal got out=%0d tc=%b done=%b busy=%b exp 9 1 1 0",
                   bus.out, bus.tc, bus.done, bus.busy);
        end
      end
    end
  endtask

  task automatic test_auto();
    int tc_cnt;
    tc_cnt = 0;
    drive(1, 1, 1, 0, 0);
    cyc();
    void'(exp_q.pop_front());
    drive(0, 1, 1, 0, 0);
    for (int i = 1; i <= 25; i++) begin
      logic [W-1:0] e;
      cyc();
      e = exp_q.pop_front();
      if (bus.tc === 1'b1) tc_cnt++;
      checks++;
      if (got_vec() !== e || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL auto_cyc%0d got %h exp %h", i, got_vec(), e);
      end
    end
    checks++;
    if (tc_cnt != 2) begin
      errors++;
      $display("FAIL auto_tc_count got %0d exp 2", tc_cnt);
    end
  endtask

  task automatic test_load();
    logic [W-1:0] e;
    drive(0, 1, 1, 1, 3);
    cyc();
    drive(0, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (got_vec() !== e) begin
        errors++;
        $display("FAIL load3_step%0d got %h exp %h", i, got_vec(), e);
      end
      if (i == 4) begin
        checks++;
        if (bus.tc !== 1'b1 || bus.out !== 4'd9) begin
          errors++;
          $display("FAIL load3_tc got tc=%b out=%0d exp tc=1 out=9", bus.tc, bus.out);
        end
      end
      if (i < 4) cyc();
    end
    drive(0, 1, 1, 1, 12);
    cyc();
    e = exp_q.pop_front();
    checks++;
    if (got_vec() !== e || bus.out !== 4'd9 || bus.err !== 1'b1) begin
      errors++;
      $display("FAIL load_bad got %h exp %h", got_vec(), e);
    end
    drive(0, 1, 1, 1, 5);
    cyc();
    e = exp_q.pop_front();
    checks++;
    if (got_vec() !== e || bus.out !== 4'd5 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL load_good got %h exp %h", got_vec(), e);
    end
  endtask

  task automatic test_hold_and_terminal_load();
    logic [W-1:0] e;
    drive(0, 0, 1, 1, 6);
    cyc();
    void'(exp_q.pop_front());
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (got_vec() !== e || bus.out !== 4'd6 || bus.tc !== 1'b0) begin
        errors++;
        $display("FAIL hold_cyc%0d got %h exp %h", i, got_vec(), e);
      end
    end
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      void'(exp_q.pop_front());
    end
    checks++;
    if (bus.out !== 4'd0) begin
      errors++;
      $display("FAIL reach_zero got %0d exp 0", bus.out);
    end
    drive(0, 1, 0, 1, 4);
    cyc();
    e = exp_q.pop_front();
    checks++;
    if (got_vec() !== e || {bus.out, bus.tc, bus.busy} !== {4'd4, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL terminal_load got %h exp %h", got_vec(), e);
    end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] e;
    drive(0, 1, 1, 1, 4);
    cyc();
    void'(exp_q.pop_front());
    drive(0, 1, 1, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.out, bus.busy, bus.tc} !== {4'd9, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got out=%0d busy=%b tc=%b exp 9 0 0", bus.out, bus.busy, bus.tc);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.tc !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_held got tc=%b busy=%b exp 0 0", bus.tc, bus.busy);
    end
    rst = 1'b0;
    model_reset();
    exp_q.delete();
    cyc();
    e = exp_q.pop_front();
    checks++;
    if (got_vec() !== e) begin
      errors++;
      $display("FAIL async_resume got %h exp %h", got_vec(), e);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] e;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
            ($urandom_range(0, 11) == 0), $urandom_range(0, 15));
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (got_vec() !== e) begin
        errors++;
        $display("FAIL random_cyc%0d got %h exp %h", i, got_vec(), e);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive(0, 0, 0, 0, 0);
    model_reset();
    test_reset();
    test_oneshot();
    test_auto();
    test_load();
    test_hold_and_terminal_load();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/modn_dnctr.md
MODN_DNCTR -- requirements
Module: modn_dnctr

Interface
REQ-001 SHALL have parameter N, default 10: counter modulus; legal range 2 <= N <= 2**WIDTH.
REQ-002 SHALL have parameter WIDTH, default 4: count width in bits.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: begin counting; sampled in IDLE and DONE only.
REQ-006 SHALL have port en, input, 1 bit: count enable; sampled in RUN only.
REQ-007 SHALL have port auto, input, 1 bit: 1 = auto-reload, 0 = one-shot; sampled at the terminal edge.
REQ-008 SHALL have port load, input, 1 bit: synchronous load request, valid in any state.
REQ-009 SHALL have port load_val, input, WIDTH bits: value applied on load.
REQ-010 SHALL have port out, output, WIDTH bits: current count, registered.
REQ-011 SHALL have port tc, output, 1 bit: terminal-count pulse, registered.
REQ-012 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-013 SHALL have port done, output, 1 bit: high while in DONE.
REQ-014 SHALL have port err, output, 1 bit: sticky flag for an out-of-range load.

Function
REQ-015 SHALL implement an FSM with states IDLE, RUN and DONE; busy = (state==RUN) and done = (state==DONE), both decoded from the state register.
REQ-016 IDLE: start=1 SHALL transition to RUN on the next edge; otherwise stay; out holds.
REQ-017 RUN, en=0: out, tc=0 and state SHALL hold.
REQ-018 RUN, en=1, out>0: out SHALL become out-1 on the edge.
REQ-019 RUN, en=1, out==0 (terminal edge): out SHALL become N-1 and tc SHALL be 1 for exactly the following cycle.
REQ-020 At the terminal edge, auto=1 SHALL keep the FSM in RUN (continuous wrap 0->N-1) and auto=0 SHALL move it to DONE.
REQ-021 DONE: start=1 SHALL transition to RUN with out unchanged; otherwise stay; start in RUN SHALL be ignored.
REQ-022 load=1 with load_val <= N-1: out SHALL become load_val and err SHALL clear; state is unchanged.
REQ-023 load=1 with load_val >= N: out SHALL become N-1 and err SHALL set, remaining set until a valid load or reset.
REQ-024 Load SHALL have priority over counting; load on a terminal edge SHALL suppress tc and the state transition.
REQ-025 A load alone SHALL never assert tc.
REQ-026 tc SHALL be 0 in every cycle not immediately following a terminal edge.
REQ-027 out SHALL never exceed N-1; decrement arithmetic is unsigned at WIDTH bits with no underflow past 0.

Reset
REQ-028 rst=1 SHALL immediately, without a clock edge, force state=IDLE, out=N-1, tc=0, busy=0, done=0, err=0.
REQ-029 While rst=1, all inputs SHALL be ignored; operation SHALL resume on the first rising edge after rst falls.
REQ-030 rst asserted mid-RUN SHALL abort the count with no tc.

Verification
REQ-031 rst=1 for 2 cycles, then 0 -> out=9, tc=0, busy=0, done=0, err=0.
REQ-032 start pulse, en=1, auto=0 -> out 9,8,...,0 over 10 cycles, then out=9, tc=1 for one cycle, done=1, busy=0, out holds 9.
REQ-033 auto=1, en=1 for 25 cycles -> out wraps 0->9 with a tc pulse every 10 cycles; busy stays 1.
REQ-034 During RUN, load_val=3 -> out 3,2,1,0 then tc; load_val=12 -> out=9, err=1; then load_val=5 -> out=5, err=0.
REQ-035 en=0 for 3 cycles at out=6 -> out holds 6; load=1 (load_val=4) on the out==0 terminal edge -> out=4, no tc, still RUN.
REQ-036 rst raised between edges with out=4 in RUN -> out=9, busy=0 before the next clk edge, no tc.
